pixel_loader: RTL and testbench

PIXEL_LOADER -- requirements
Module: pixel_loader

---
 rtl/pixel_loader.sv | 178 +++++++++++++++++
 tb/tb_pixel_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_loader.sv
// Assembles UART bytes (R, G, B) into 18-bit pixels and writes them row-major into a frame BRAM.
// Optional mid-pixel idle timeout is enabled with `define PIXEL_LOADER_TIMEOUT_EN.
module pixel_loader #(
  parameter int unsigned H_SIZE         = 607,
  parameter int unsigned V_SIZE         = 455,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  rx_byte,
  input  logic        rx_flag,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [17:0] wr_data,
  output logic        loaded,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_R    = 2'd0,
    S_G    = 2'd1,
    S_B    = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [18:0] LastAddr = 19'(H_SIZE * V_SIZE - 1);

  state_e      state_q, state_d;
  logic [5:0]  r_q, r_d;
  logic [5:0]  g_q, g_d;
  logic [18:0] count_q, count_d;
  logic        wr_en_q, wr_en_d;
  logic [18:0] wr_addr_q, wr_addr_d;
  logic [17:0] wr_data_q, wr_data_d;
  logic        loaded_q, loaded_d;

  // Only the top six bits of each colour byte are kept.
  logic unused_rx_lsbs;
  assign unused_rx_lsbs = ^rx_byte[1:0];

`ifdef PIXEL_LOADER_TIMEOUT_EN
  localparam int unsigned IdleW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IdleW-1:0] IdleLimit = IdleW'(TIMEOUT_CYCLES - 1);

  logic [IdleW-1:0] idle_q, idle_d;
  logic             timeout_q, timeout_d;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    g_d       = g_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    loaded_d  = loaded_q;
`ifdef PIXEL_LOADER_TIMEOUT_EN
    idle_d    = idle_q;
    timeout_d = 1'b0;
`endif

    if (clear) begin
      // Restart wins over a byte arriving in the same cycle; that byte is lost.
      state_d  = S_R;
      r_d      = '0;
      g_d      = '0;
      count_d  = '0;
      loaded_d = 1'b0;
`ifdef PIXEL_LOADER_TIMEOUT_EN
      idle_d   = '0;
`endif
    end else begin
      unique case (state_q)
        S_R: begin
          if (rx_flag) begin
            r_d     = rx_byte[7:2];
            state_d = S_G;
          end
        end
        S_G: begin
          if (rx_flag) begin
            g_d     = rx_byte[7:2];
            state_d = S_B;
          end
        end
        S_B: begin
          if (rx_flag) begin
            wr_en_d   = 1'b1;
            wr_addr_d = count_q;
            wr_data_d = {r_q, g_q, rx_byte[7:2]};
            if (count_q == LastAddr) begin
              // Count saturates on the final pixel; only clear/reset rewinds it.
              state_d  = S_DONE;
              loaded_d = 1'b1;
            end else begin
              count_d = count_q + 19'd1;
              state_d = S_R;
            end
          end
        end
        S_DONE: begin
          loaded_d = 1'b1;
        end
        default: begin
          state_d = S_R;
        end
      endcase

`ifdef PIXEL_LOADER_TIMEOUT_EN
      if (state_q == S_G || state_q == S_B) begin
        if (rx_flag) begin
          idle_d = '0;
        end else if (idle_q == IdleLimit) begin
          // Stalled mid-pixel: drop the partial colour and resync on the next R byte.
          state_d   = S_R;
          r_d       = '0;
          g_d       = '0;
          idle_d    = '0;
          timeout_d = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end else begin
        idle_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_R;
      r_q       <= '0;
      g_q       <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      loaded_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      g_q       <= g_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      loaded_q  <= loaded_d;
    end
  end

`ifdef PIXEL_LOADER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign loaded  = loaded_q;

endmodule

// File: tb/tb_pixel_loader.sv
// Directed scoreboard bench for pixel_loader (4x2 image, 20-cycle timeout).
module tb_pixel_loader;

  localparam int unsigned HS = 4;
  localparam int unsigned VS = 2;
  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [7:0]  rx_byte;
  logic        rx_flag;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [17:0] wr_data;
  logic        loaded;
  logic        timeout_err;

  pixel_loader #(
    .H_SIZE        (HS),
    .V_SIZE        (VS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .rx_byte    (rx_byte),
    .rx_flag    (rx_flag),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .loaded     (loaded),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [18:0] addr;
    logic [17:0] data;
    logic        ld;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  to_pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (timeout_err === 1'b1) to_pulses++;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr_en_addr", 32'(wr_addr), 32'h7FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
        check("loaded_with_wr", 32'(loaded), 32'(e.ld));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_flag = 1'b1;
    @(posedge clk);
    #1;
    rx_flag = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [18:0] a, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b, input logic ld);
    wr_t e;
    e.addr = a;
    e.data = {r[7:2], g[7:2], b[7:2]};
    e.ld   = ld;
    exp_q.push_back(e);
  endtask

  task automatic pixel(input logic [18:0] a, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic ld);
    send(r);
    send(g);
    expect_wr(a, r, g, b, ld);
    send(b);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r, g, b;
    reset   = 1'b1;
    clear   = 1'b0;
    rx_byte = 8'h00;
    rx_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);

    // First pixel: 0xFC,0x80,0x03 -> 0x3F800 at address 0.
    pixel(19'd0, 8'hFC, 8'h80, 8'h03, 1'b0);
    check("px0_expected_data", 32'({6'h3F, 6'h20, 6'h00}), 32'h3F800);
    check("px0_not_loaded", 32'(loaded), 32'd0);

    // Rest of the image; loaded rises with the eighth write.
    for (int i = 1; i < 8; i++) begin
      r = 8'($urandom);
      g = 8'($urandom);
      b = 8'($urandom);
      pixel(19'(i), r, g, b, (i == 7));
    end
    repeat (2) @(posedge clk);
    #1;
    check("full_loaded", 32'(loaded), 32'd1);
    check("full_wr_addr_hold", 32'(wr_addr), 32'd7);

    // Extra bytes after completion are ignored.
    send(8'h11);
    send(8'h22);
    send(8'h33);
    check("done_loaded_held", 32'(loaded), 32'd1);
    check("done_no_write_addr", 32'(wr_addr), 32'd7);

    // Clear restarts at address 0.
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear_loaded", 32'(loaded), 32'd0);
    pixel(19'd0, 8'h40, 8'h80, 8'hC0, 1'b0);

    // Partial pixel discarded by reset.
    send(8'hAA);
    send(8'hBB);
    pulse_reset();
    check("midrst_wr_addr", 32'(wr_addr), 32'd0);
    check("midrst_wr_data", 32'(wr_data), 32'd0);
    pixel(19'd0, 8'h04, 8'h08, 8'h0C, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_px_data", 32'(wr_data), 32'h01083);

    // Idle mid-pixel.
    pulse_reset();
    to_pulses = 0;
    send(8'hF0);
    repeat (TO + 5) @(posedge clk);
    #1;
`ifdef PIXEL_LOADER_TIMEOUT_EN
    check("timeout_pulses", 32'(to_pulses), 32'd1);
    pixel(19'd0, 8'h14, 8'h28, 8'h3C, 1'b0);
`else
    check("timeout_pulses", 32'(to_pulses), 32'd0);
    send(8'h28);
    expect_wr(19'd0, 8'hF0, 8'h28, 8'h3C, 1'b0);
    send(8'h3C);
`endif

    // Clear together with a byte: the byte is dropped and count returns to 0.
    send(8'hAA);
    clear   = 1'b1;
    rx_byte = 8'h55;
    rx_flag = 1'b1;
    @(posedge clk);
    #1;
    clear   = 1'b0;
    rx_flag = 1'b0;
    pixel(19'd0, 8'h10, 8'h20, 8'h30, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("final_loaded", 32'(loaded), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
